countdown_timer_p: RTL and testbench
====================================

# countdown_timer_p

Parametrised minute/second timer core for the Nexys A7 display path. It replaces the free-running derived 1 s clock with a single-clock prescaler enable, and does its own edge detection of the start, pause and stop buttons. It adds a count-up (stopwatch-to-target) mode, a terminal DONE state, input saturation and BCD outputs that feed straight into the 7-segment driver's digit inputs.

## Interface
Parameters:
- TICK_COUNT, 50000000, clock cycles per one-second tick (≥2)
- MIN_MAX, 99, maximum minutes value (≤99)

Ports:
- clock  in  1  system clock; the only clock in the block
- reset  in  1  asynchronous, active-low reset (0 = reset)
- start  in  1  raw level button; acts on its rising edge
- pause  in  1  raw level button; acts on its rising edge
- stop  in  1  raw level button; acts on its rising edge
- up_mode  in  1  0 = count down from preset; 1 = count up from 0:00 to preset; sampled on start
- min  in  7  preset minutes; saturated to MIN_MAX
- sec  in  7  preset seconds; saturated to 59
- state  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
- done  out  1  high while state = DONE
- tick  out  1  one-cycle pulse on each one-second tick while in RUN
- min_left  out  7  current minutes
- sec_left  out  6  current seconds
- min_bcd  out  8  {tens, ones} of min_left
- sec_bcd  out  8  {tens, ones} of sec_left

## Operation
- Edge detection: each button is registered once (btn_q). The event is btn & ~btn_q, evaluated every cycle. No synchroniser is included; callers provide debounced, synchronous inputs.
- Event priority within one cycle: stop > pause > start.
- IDLE
  - Every cycle, target <= sat(min), sat(sec).
  - Count shows target when up_mode = 0, or 0:00 when up_mode = 1.
  - Prescaler is held at 0.
  - On start: latch mode and target, then go to RUN.
  - If the starting count already equals the terminal value, go to DONE instead of RUN. The terminal value is 0:00 in down mode and target in up mode.
- RUN
  - Prescaler counts 0..TICK_COUNT-1. tick is asserted when it wraps.
  - Down mode, on tick:
    - sec > 0: sec - 1.
    - otherwise: min - 1 and sec = 59.
  - Up mode, on tick:
    - sec < 59: sec + 1.
    - otherwise: sec = 0 and min + 1.
  - A tick that produces the terminal value moves the state to DONE on the same edge.
  - pause moves to PAUSE. stop moves to IDLE.
- PAUSE
  - Prescaler and count are frozen.
  - pause or start returns to RUN, and the prescaler resumes from its frozen value.
  - stop moves to IDLE.
- DONE
  - Count is held at the terminal value.
  - start or stop moves to IDLE. A new start press is then needed to run.
  - pause is ignored.
- Changes to min, sec and up_mode outside IDLE have no effect.
- BCD conversion is combinational from the count registers: tens = v/10, ones = v%10.
- Reset (reset = 0, any time, including mid-run):
  - state = IDLE, prescaler = 0, min_left = sec_left = 0, target = 0, btn_q = 0.
  - done = 0, tick = 0, min_bcd = sec_bcd = 8'h00.
  - The first IDLE clock after reset release loads the preset.

## Timing
- A button is acted on at the first rising clock edge where it is sampled 1 after being sampled 0. The state is visible the next cycle.
- A button held high generates exactly one event. A button already high at reset release generates one event, because btn_q resets to 0.
- The first tick occurs TICK_COUNT cycles after the edge that enters RUN. Subsequent ticks are every TICK_COUNT cycles of RUN time, excluding PAUSE time.
- The count and state registers update on the tick edge. done and the new count become visible together, 0 cycles apart.
- The prescaler width is clog2(TICK_COUNT). No register wraps outside the ranges defined above.

## Test plan
Bench parameters: TICK_COUNT = 4, MIN_MAX = 99.
- Down count: reset, min = 1, sec = 2, start pulse → RUN. Then 1:01 at +4 cycles, 1:00, 0:59 … 0:00 after 62 ticks (248 cycles). done = 1 and state = 11 from that cycle on.
- Saturation and BCD: min = 120, sec = 75 in IDLE → min_left = 99, sec_left = 59, min_bcd = 8'h99, sec_bcd = 8'h59.
- Pause: pause 2 cycles after a tick; hold 20 cycles; press pause again → the next tick comes 2 cycles after resume, and the count is unchanged during the pause.
- Up mode: up_mode = 1, min = 0, sec = 3, start → 0:01, 0:02, 0:03 at 4/8/12 cycles, then DONE. A 0:59 → 1:00 rollover is checked with sec = 60 (saturated to 59) and min = 1.
- Priority and zero start:
  - stop and pause rising in the same cycle during RUN → IDLE.
  - start with preset 0:00 in down mode → DONE the next cycle, with no tick.
- Reset mid-run: assert reset = 0 asynchronously between clock edges at 0:30 → all outputs go to their reset values immediately. After release, the state stays IDLE until a new start edge.

Source files
------------

// File: rtl/countdown_timer_p.sv
// Minute/second timer core: single-clock prescaler enable, button edge detection,
// count-down / count-up-to-target modes, terminal DONE state and BCD display outputs.
module countdown_timer_p #(
  parameter int unsigned TICK_COUNT = 50000000,
  parameter int unsigned MIN_MAX    = 99
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       stop,
  input  logic       up_mode,
  input  logic [6:0] min,
  input  logic [6:0] sec,
  output logic [1:0] state,
  output logic       done,
  output logic       tick,
  output logic [6:0] min_left,
  output logic [5:0] sec_left,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd
);

  localparam int unsigned PW = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_COUNT - 1);
  localparam logic [6:0] MIN_SAT = 7'(MIN_MAX);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [6:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  logic [6:0]    tmin_q, tmin_d;
  logic [5:0]    tsec_q, tsec_d;
  logic          mode_q, mode_d;
  logic [2:0]    btn_q, btn_d;

  logic       start_ev, pause_ev, stop_ev;
  logic [6:0] min_sat, step_min;
  logic [5:0] sec_sat, step_sec;
  logic       wrap, at_term;

  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  // btn_q is {stop, pause, start}
  assign btn_d    = {stop, pause, start};
  assign start_ev = start & ~btn_q[0];
  assign pause_ev = pause & ~btn_q[1];
  assign stop_ev  = stop  & ~btn_q[2];

  assign min_sat = (min > MIN_SAT) ? MIN_SAT : min;
  assign sec_sat = (sec > 7'd59) ? 6'd59 : sec[5:0];
  assign wrap    = (presc_q == PRESC_LAST);

  always_comb begin
    step_min = min_q;
    step_sec = sec_q;
    if (mode_q) begin
      if (sec_q < 6'd59) begin
        step_sec = sec_q + 6'd1;
      end else begin
        step_sec = '0;
        step_min = min_q + 7'd1;
      end
    end else begin
      if (sec_q != '0) begin
        step_sec = sec_q - 6'd1;
      end else begin
        step_sec = 6'd59;
        step_min = min_q - 7'd1;
      end
    end
  end

  assign at_term = mode_q ? ((step_min == tmin_q) && (step_sec == tsec_q))
                          : ((step_min == '0) && (step_sec == '0));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      tmin_q  <= '0;
      tsec_q  <= '0;
      mode_q  <= 1'b0;
      btn_q   <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      tmin_q  <= tmin_d;
      tsec_q  <= tsec_d;
      mode_q  <= mode_d;
      btn_q   <= btn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    min_d   = min_q;
    sec_d   = sec_q;
    tmin_d  = tmin_q;
    tsec_d  = tsec_q;
    mode_d  = mode_q;
    unique case (state_q)
      S_IDLE: begin
        tmin_d  = min_sat;
        tsec_d  = sec_sat;
        mode_d  = up_mode;
        presc_d = '0;
        min_d   = up_mode ? '0 : min_sat;
        sec_d   = up_mode ? '0 : sec_sat;
        // Both modes start already terminal exactly when the preset is 0:00.
        if (start_ev && !stop_ev)
          state_d = ((min_sat == '0) && (sec_sat == '0)) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        presc_d = wrap ? '0 : presc_q + 1'b1;
        if (wrap) begin
          min_d = step_min;
          sec_d = step_sec;
        end
        if (stop_ev) begin
          state_d = S_IDLE;
          presc_d = '0;
        end else if (wrap && at_term) begin
          state_d = S_DONE;
        end else if (pause_ev) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (stop_ev) begin
          state_d = S_IDLE;
          presc_d = '0;
        end else if (pause_ev || start_ev) begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (stop_ev || start_ev) begin
          state_d = S_IDLE;
          presc_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    state    = state_q;
    done     = (state_q == S_DONE);
    tick     = (state_q == S_RUN) && wrap;
    min_left = min_q;
    sec_left = sec_q;
    min_bcd  = to_bcd(min_q);
    sec_bcd  = to_bcd({1'b0, sec_q});
  end

endmodule

// File: tb/tb_countdown_timer_p.sv
// Directed bench for countdown_timer_p with TICK_COUNT=4: down/up counting, saturation,
// BCD, pause timing, event priority, zero start and asynchronous reset mid-run.
module tb_countdown_timer_p;

  logic       clock = 1'b0;
  logic       reset;
  logic       start, pause, stop, up_mode;
  logic [6:0] min, sec;
  logic [1:0] state;
  logic       done, tick;
  logic [6:0] min_left;
  logic [5:0] sec_left;
  logic [7:0] min_bcd, sec_bcd;

  int total = 0;
  int bad   = 0;

  countdown_timer_p #(.TICK_COUNT(4), .MIN_MAX(99)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .pause    (pause),
    .stop     (stop),
    .up_mode  (up_mode),
    .min      (min),
    .sec      (sec),
    .state    (state),
    .done     (done),
    .tick     (tick),
    .min_left (min_left),
    .sec_left (sec_left),
    .min_bcd  (min_bcd),
    .sec_bcd  (sec_bcd)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cnt(input string tag, input int m, input int s);
    check({tag, "_min"}, 32'(min_left), 32'(m));
    check({tag, "_sec"}, 32'(sec_left), 32'(s));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0; up_mode = 1'b0;
    min = 7'd0; sec = 7'd0;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check_cnt("rst_cnt", 0, 0);
    check("rst_mbcd", 32'(min_bcd), 32'h00);
    check("rst_sbcd", 32'(sec_bcd), 32'h00);
    cyc(2);
    reset = 1'b1;

    // saturation and BCD
    min = 7'd120; sec = 7'd75;
    cyc(1);
    check_cnt("sat", 99, 59);
    check("sat_mbcd", 32'(min_bcd), 32'h99);
    check("sat_sbcd", 32'(sec_bcd), 32'h59);

    // down count 1:02 -> 0:00
    min = 7'd1; sec = 7'd2;
    cyc(1);
    check_cnt("preset", 1, 2);
    check("preset_sbcd", 32'(sec_bcd), 32'h02);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("dn_run", 32'(state), 32'd1);
    check("dn_tick0", 32'(tick), 32'd0);
    cyc(3);
    check("dn_tick1", 32'(tick), 32'd1);
    check_cnt("dn_pre1", 1, 2);
    cyc(1);
    check_cnt("dn_101", 1, 1);
    check("dn_tick_lo", 32'(tick), 32'd0);
    cyc(4);
    check_cnt("dn_100", 1, 0);
    cyc(4);
    check_cnt("dn_059", 0, 59);
    check("dn_059_mbcd", 32'(min_bcd), 32'h00);
    check("dn_059_sbcd", 32'(sec_bcd), 32'h59);
    cyc(235);
    check_cnt("dn_001", 0, 1);
    check("dn_last_tick", 32'(tick), 32'd1);
    check("dn_last_run", 32'(state), 32'd1);
    cyc(1);
    check_cnt("dn_000", 0, 0);
    check("dn_done", 32'(done), 32'd1);
    check("dn_state_done", 32'(state), 32'd3);
    pause = 1'b1;
    cyc(1);
    pause = 1'b0;
    check("done_pause_ign", 32'(state), 32'd3);
    cyc(4);
    check("done_hold", 32'(state), 32'd3);
    check_cnt("done_cnt", 0, 0);
    check("done_notick", 32'(tick), 32'd0);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("done_to_idle", 32'(state), 32'd0);
    check("idle_done_lo", 32'(done), 32'd0);
    cyc(1);
    check_cnt("idle_reload", 1, 2);

    // pause timing
    min = 7'd0; sec = 7'd10;
    cyc(1);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(4);
    check_cnt("p_009", 0, 9);
    cyc(1);
    pause = 1'b1;
    cyc(1);
    pause = 1'b0;
    check("p_paused", 32'(state), 32'd2);
    cyc(20);
    check("p_hold_state", 32'(state), 32'd2);
    check_cnt("p_hold_cnt", 0, 9);
    check("p_hold_tick", 32'(tick), 32'd0);
    pause = 1'b1;
    cyc(1);
    pause = 1'b0;
    check("p_resume", 32'(state), 32'd1);
    cyc(1);
    check("p_tick_after", 32'(tick), 32'd1);
    check_cnt("p_pre_tick", 0, 9);
    cyc(1);
    check_cnt("p_008", 0, 8);

    // stop beats pause in the same cycle
    stop = 1'b1; pause = 1'b1;
    cyc(1);
    stop = 1'b0; pause = 1'b0;
    check("prio_idle", 32'(state), 32'd0);
    cyc(1);
    check_cnt("prio_reload", 0, 10);

    // zero preset in down mode
    min = 7'd0; sec = 7'd0;
    cyc(1);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("zero_done", 32'(state), 32'd3);
    check("zero_done_o", 32'(done), 32'd1);
    check("zero_notick", 32'(tick), 32'd0);
    cyc(1);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("zero_idle", 32'(state), 32'd0);

    // up mode to 0:03
    up_mode = 1'b1; min = 7'd0; sec = 7'd3;
    cyc(1);
    check_cnt("up_idle", 0, 0);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("up_run", 32'(state), 32'd1);
    cyc(4);
    check_cnt("up_001", 0, 1);
    cyc(4);
    check_cnt("up_002", 0, 2);
    cyc(3);
    check("up_tick", 32'(tick), 32'd1);
    check("up_not_done", 32'(done), 32'd0);
    cyc(1);
    check_cnt("up_003", 0, 3);
    check("up_done", 32'(state), 32'd3);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    check("up_stop_idle", 32'(state), 32'd0);

    // up mode rollover, target 1:59 after saturation
    min = 7'd1; sec = 7'd60;
    cyc(1);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(239);
    check_cnt("roll_059", 0, 59);
    check("roll_059_run", 32'(state), 32'd1);
    cyc(1);
    check_cnt("roll_100", 1, 0);
    check("roll_mbcd", 32'(min_bcd), 32'h01);
    check("roll_sbcd", 32'(sec_bcd), 32'h00);
    check("roll_run", 32'(state), 32'd1);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;

    // asynchronous reset mid-run at 0:30
    up_mode = 1'b0; min = 7'd0; sec = 7'd32;
    cyc(1);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(8);
    check_cnt("mr_030", 0, 30);
    #2;
    reset = 1'b0;
    #1;
    check("mr_state", 32'(state), 32'd0);
    check_cnt("mr_cnt", 0, 0);
    check("mr_done", 32'(done), 32'd0);
    check("mr_tick", 32'(tick), 32'd0);
    check("mr_mbcd", 32'(min_bcd), 32'h00);
    check("mr_sbcd", 32'(sec_bcd), 32'h00);
    #2;
    reset = 1'b1;
    cyc(1);
    check_cnt("mr_reload", 0, 32);
    cyc(10);
    check("mr_stay_idle", 32'(state), 32'd0);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("mr_restart", 32'(state), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
